// File: rtl/psi_stream.sv
// Streaming N-party set intersection over sorted lists; match out one cycle after the all-equal step, output held under out_ready=0.
// in_ready is combinational and withheld while the output slot is full; define PSI_DEDUP_EN to emit a strict set.
module psi_stream #(
   parameter int W     = 32,
   parameter int N     = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     in_valid,
   input  logic [W*N-1:0]   in_data,
   input  logic [N-1:0]     in_last,
   output logic [N-1:0]     in_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] match_count,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

   state_t         state;
   logic [N-1:0]   finished;
   logic [W-1:0]   head [N];
   logic [W-1:0]   max_head;
   logic [N-1:0]   lt_max;
   logic [N-1:0]   pop;
   logic [N-1:0]   fin_next;
   logic           all_eq;
   logic           slot_free;
   logic           step;
   logic           dup;
   logic           emit;

   for (genvar g = 0; g < N; g++) begin : g_head
      assign head[g] = in_data[g*W +: W];
   end

   always_comb begin
      max_head = head[0];
      all_eq   = 1'b1;
      for (int i = 1; i < N; i++) begin
         if (head[i] > max_head) max_head = head[i];
         if (head[i] != head[0]) all_eq = 1'b0;
      end
      lt_max = '0;
      for (int i = 0; i < N; i++) begin
         lt_max[i] = head[i] < max_head;
      end
   end

   assign slot_free = !out_valid || out_ready;
   assign step      = (state == RUN) && (&in_valid) && slot_free;

`ifdef PSI_DEDUP_EN
   logic         hist_vld;
   logic [W-1:0] hist_dat;

   assign dup = hist_vld && (head[0] == hist_dat);

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_vld <= 1'b0;
         hist_dat <= '0;
      end else if (state == IDLE && start) begin
         hist_vld <= 1'b0;
      end else if (emit) begin
         hist_vld <= 1'b1;
         hist_dat <= head[0];
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign emit = step && all_eq && !dup;

   // A non-matching step always pops the smaller heads, so unsorted input cannot stall the run.
   always_comb begin
      in_ready = '0;
      case (state)
         RUN:     if (step) in_ready = all_eq ? {N{1'b1}} : lt_max;
         FLUSH:   in_ready = in_valid & ~finished;
         default: in_ready = '0;
      endcase
   end

   assign pop      = in_ready & in_valid;
   assign fin_next = finished | (pop & in_last);
   assign done     = (state == FIN) && slot_free;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         finished    <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         match_count <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (emit) begin
            out_valid <= 1'b1;
            out_data  <= head[0];
            if (match_count != {CNT_W{1'b1}}) match_count <= match_count + CNT_W'(1);
         end
         case (state)
            IDLE: begin
               if (start) begin
                  match_count <= '0;
                  finished    <= '0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (step) begin
                  finished <= fin_next;
                  if (|fin_next) state <= (&fin_next) ? FIN : FLUSH;
               end
            end
            FLUSH: begin
               finished <= fin_next;
               if (&fin_next) state <= FIN;
            end
            FIN: begin
               if (slot_free) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psi_stream.sv
// Directed bench for psi_stream: an intersection model built from whole lists feeds a scoreboard checked on every accepted output.
module tb_psi_stream;
   localparam int W     = 8;
   localparam int N     = 4;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [N-1:0]     in_valid;
   logic [W*N-1:0]   in_data;
   logic [N-1:0]     in_last;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             out_ready;
   logic [CNT_W-1:0] match_count;
   logic             done;
   logic             busy;

   psi_stream #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .match_count(match_count), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc_n       = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   logic [W-1:0] lst [N][16];
   int           len [N];
   int           idx [N];
   logic [W-1:0] exp_q [$];
   int           acc_cyc [$];

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_list(input int ch, input int n, input int v0 = 0, input int v1 = 0,
                           input int v2 = 0, input int v3 = 0, input int v4 = 0, input int v5 = 0);
      int v [6];
      v = '{v0, v1, v2, v3, v4, v5};
      len[ch] = n;
      for (int i = 0; i < 16; i++) lst[ch][i] = (i < 6) ? W'(v[i]) : '0;
   endtask

   // Intersection as a multiset: each value appears min-over-parties times (once with dedup).
   function automatic void build_model();
      exp_q.delete();
      for (int v = 0; v < 256; v++) begin
         int m = 1000;
         for (int ch = 0; ch < N; ch++) begin
            int c = 0;
            for (int i = 0; i < len[ch]; i++) if (lst[ch][i] == W'(v)) c++;
            if (c < m) m = c;
         end
`ifdef PSI_DEDUP_EN
         if (m > 1) m = 1;
`endif
         for (int k = 0; k < m; k++) exp_q.push_back(W'(v));
      end
   endfunction

   function automatic void drive_inputs();
      for (int ch = 0; ch < N; ch++) begin
         in_valid[ch]          = idx[ch] < len[ch];
         in_data[ch*W +: W]    = (idx[ch] < len[ch]) ? lst[ch][idx[ch]] : '0;
         in_last[ch]           = (idx[ch] == len[ch] - 1);
      end
   endfunction

   // Scoreboard: every accepted output against the model, and stability while stalled.
   logic         prev_hold = 1'b0;
   logic [W-1:0] prev_dat  = '0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_data, prev_dat);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL extra_output: got %0d expected none", out_data);
               end else begin
                  logic [W-1:0] e;
                  e = exp_q.pop_front();
                  chk("out_data", out_data, e);
               end
               acc_cyc.push_back(cyc_n);
            end
            if (done) chk("outputs_left_at_done", exp_q.size(), 0);
            prev_hold = out_valid && !out_ready;
            prev_dat  = out_data;
         end
      end
   end

   task automatic step_cycle(output logic [N-1:0] pop);
      @(negedge clk);
      pop = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int ch = 0; ch < N; ch++) if (pop[ch]) idx[ch]++;
      drive_inputs();
   endtask

   task automatic run(input bit hold, input int exp_n, input bit consec);
      int last_pop = -1;
      int done_cyc = -1;
      int held     = 0;
      logic [N-1:0] pop;
      build_model();
      chk("model_len", exp_q.size(), exp_n);
      acc_cyc.delete();
      for (int ch = 0; ch < N; ch++) idx[ch] = 0;
      drive_inputs();
      out_ready = !hold;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 0; k < 200 && done_cyc < 0; k++) begin
         @(negedge clk);
         pop = in_valid & in_ready;
         if (|pop) last_pop = cyc_n;
         if (hold && out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            held++;
         end
         if (done) done_cyc = cyc_n;
         @(posedge clk);
         #1;
         for (int ch = 0; ch < N; ch++) if (pop[ch]) idx[ch]++;
         drive_inputs();
         if (held >= 5) out_ready = 1'b1;
      end
      if (done_cyc < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: got no done expected done within 200 cycles");
      end else begin
         chk("done_timing", done_cyc, last_pop + 1);
      end
      chk("busy_after_done", busy, 0);
      chk("match_count", match_count, (exp_n > 3) ? 3 : exp_n);
      chk("all_outputs_seen", exp_q.size(), 0);
      if (hold) chk("stall_cycles", held, 5);
      @(negedge clk);
      chk("done_pulse_width", done, 0);
      if (consec) for (int i = 0; i + 1 < acc_cyc.size(); i++)
         chk("back_to_back", acc_cyc[i+1] - acc_cyc[i], 1);
      @(posedge clk);
      #1;
   endtask

   task automatic lists_basic();
      set_list(0, 4, 1, 3, 5, 7);
      set_list(1, 4, 3, 4, 5, 9);
      set_list(2, 4, 0, 3, 5, 7);
      set_list(3, 4, 0, 3, 5, 7);
   endtask

   initial begin
      logic [N-1:0] pop;
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      in_valid = '1; in_data = '0; in_last = '0;
      for (int ch = 0; ch < N; ch++) begin len[ch] = 0; idx[ch] = 0; end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_match_count", match_count, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      @(posedge clk);
      #1;

      // Three parties (fourth mirrors the third): expect 3 then 5.
      lists_basic();
      build_model();
      chk("model_basic_0", exp_q[0], 3);
      chk("model_basic_1", exp_q[1], 5);
      run(1'b0, 2, 1'b0);

      // Two parties mirrored, output stalled for five cycles after the first match.
      set_list(0, 4, 2, 5, 6, 7);
      set_list(1, 5, 1, 2, 5, 6, 7);
      set_list(2, 4, 2, 5, 6, 7);
      set_list(3, 5, 1, 2, 5, 6, 7);
      build_model();
      chk("model_hold_0", exp_q[0], 2);
      chk("model_hold_3", exp_q[3], 7);
      run(1'b1, 4, 1'b1);

      // Duplicates with simultaneous last on every party.
      for (int ch = 0; ch < N; ch++) set_list(ch, 3, 2, 2, 6);
      build_model();
`ifdef PSI_DEDUP_EN
      chk("model_dup_1", exp_q[1], 6);
      run(1'b0, 2, 1'b1);
`else
      chk("model_dup_1", exp_q[1], 2);
      chk("model_dup_2", exp_q[2], 6);
      run(1'b0, 3, 1'b1);
`endif

      // Disjoint lists: party 0 ends first, the rest drain.
      set_list(0, 2, 1, 2);
      for (int ch = 1; ch < N; ch++) set_list(ch, 2, 3, 4);
      run(1'b0, 0, 1'b0);

      // Six matches against a two-bit counter.
      for (int ch = 0; ch < N; ch++) set_list(ch, 6, 1, 2, 3, 4, 5, 6);
      build_model();
      chk("model_sat_5", exp_q[5], 6);
      run(1'b0, 6, 1'b1);

      // Reset while an output is pending, then a clean rerun.
      lists_basic();
      for (int ch = 0; ch < N; ch++) idx[ch] = 0;
      drive_inputs();
      out_ready = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) step_cycle(pop);
      chk("pre_reset_out_valid", out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_cycle_done", done, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_match_count", match_count, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      out_ready = 1'b1;
      lists_basic();
      run(1'b0, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
